// File: rtl/acc_sched.sv
// Round-robin front end that time-shares one accumulator; result appears 3+L cycles after the winning request.
// Backpressure: only the granted requester sees ready, during RUN; valid gaps simply stall the burst.
module acc_sched #(
    parameter int BITWIDTH = 32,
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 8,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [NUM_REQ-1:0]          iReq,
    input  logic [NUM_REQ*LEN_W-1:0]    iLen,
    input  logic [NUM_REQ-1:0]          iValid,
    input  logic [NUM_REQ*BITWIDTH-1:0] iData,
    output logic [NUM_REQ-1:0]          oGnt,
    output logic [NUM_REQ-1:0]          oReady,
    output logic                        oAccEn,
    output logic                        oAccClr,
    output logic [BITWIDTH-1:0]         oAccData,
    input  logic [BITWIDTH:0]           iAccData,
    output logic                        oDone,
    output logic [ID_W-1:0]             oDoneId,
    output logic [BITWIDTH:0]           oResult
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, WAIT} stateT;

    stateT            state;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  ptr;
    logic [LEN_W-1:0] cnt;

    logic             found;
    logic [ID_W-1:0]  winId;
    logic [ID_W-1:0]  cand;

    // Search starts one past the last served id so a persistent requester waits its turn.
    always_comb begin
        found = 1'b0;
        winId = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && iReq[cand]) begin
                found = 1'b1;
                winId = cand;
            end
        end
    end

    assign oAccClr  = (state == CLR);
    assign oReady   = (state == RUN) ? oGnt : '0;
    assign oAccEn   = (state == RUN) && iValid[id];
    assign oAccData = iData[id*BITWIDTH +: BITWIDTH];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            ptr     <= ID_W'(NUM_REQ - 1);
            cnt     <= '0;
            id      <= '0;
            oGnt    <= '0;
            oDone   <= 1'b0;
            oDoneId <= '0;
            oResult <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        id    <= winId;
                        oGnt  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winId;
                        cnt   <= iLen[winId*LEN_W +: LEN_W];
                        state <= CLR;
                    end
                end
                CLR: begin
                    ptr   <= id;
                    state <= (cnt == '0) ? WAIT : RUN;
                end
                RUN: begin
                    if (iValid[id]) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Accumulator register now holds the last word, so capture the sum here.
                    oResult <= iAccData;
                    oDoneId <= id;
                    oDone   <= 1'b1;
                    oGnt    <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// Bench for acc_sched with a behavioural accumulator attached to its accumulator port.
module tb_acc_sched;
    localparam int BW = 32;
    localparam int NR = 4;
    localparam int LW = 8;
    localparam int IW = 2;

    logic              iClk = 1'b0;
    logic              iRst;
    logic [NR-1:0]     iReq;
    logic [NR*LW-1:0]  iLen;
    logic [NR-1:0]     iValid;
    logic [NR*BW-1:0]  iData;
    logic [NR-1:0]     oGnt;
    logic [NR-1:0]     oReady;
    logic              oAccEn;
    logic              oAccClr;
    logic [BW-1:0]     oAccData;
    logic [BW:0]       accReg;
    logic              oDone;
    logic [IW-1:0]     oDoneId;
    logic [BW:0]       oResult;

    always #5 iClk = ~iClk;

    acc_sched #(.BITWIDTH(BW), .NUM_REQ(NR), .LEN_W(LW), .ID_W(IW)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iLen(iLen), .iValid(iValid), .iData(iData),
        .oGnt(oGnt), .oReady(oReady), .oAccEn(oAccEn), .oAccClr(oAccClr), .oAccData(oAccData),
        .iAccData(accReg), .oDone(oDone), .oDoneId(oDoneId), .oResult(oResult)
    );

    always_ff @(posedge iClk) begin
        if (oAccClr)     accReg <= '0;
        else if (oAccEn) accReg <= accReg + {1'b0, oAccData};
    end

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int              req;
        int              len;
        logic [7:0][31:0] words;
        logic [7:0]      vpat;
        logic [BW:0]     sum;
        int              doneCyc;
    } vecT;

    function automatic vecT mkVec(input int req, input int len,
                                  input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                  input logic [31:0] w3, input logic [31:0] w4,
                                  input logic [7:0] vp, input logic [BW:0] sum, input int dc);
        vecT v;
        v.req = req; v.len = len; v.vpat = vp; v.sum = sum; v.doneCyc = dc;
        v.words = '0;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3; v.words[4] = w4;
        return v;
    endfunction

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_gnt"},    oGnt,    '0);
        chk({tag, "_ready"},  oReady,  '0);
        chk({tag, "_accEn"},  oAccEn,  '0);
        chk({tag, "_accClr"}, oAccClr, '0);
        chk({tag, "_done"},   oDone,   '0);
        chk({tag, "_doneId"}, oDoneId, '0);
        chk({tag, "_result"}, oResult, '0);
    endtask

    task automatic doReset();
        @(negedge iClk);
        iRst = 1'b1; iReq = '0; iValid = '0; iLen = '0; iData = '0;
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        checkResetOutputs("reset");
    endtask

    // Cycle 0 is the cycle in which the arbiter sees the request.
    task automatic runVec(input vecT v, input string tag);
        logic [NR-1:0] oh, expGnt, expReady;
        logic          expEn;
        int            enCnt;
        oh = NR'(1) << v.req;
        enCnt = 0;
        for (int c = 0; c <= v.doneCyc; c++) begin
            @(negedge iClk);
            iReq = (c == 0) ? oh : '0;
            iLen = '0;
            iLen[v.req*LW +: LW] = LW'(v.len);
            iValid = ~oh;
            iData = {NR{32'hDEADBEEF}};
            if (c >= 2 && c - 2 < 8) begin
                iValid[v.req] = v.vpat[c-2];
                iData[v.req*BW +: BW] = v.words[c-2];
            end
            #1;
            expGnt   = (c >= 1 && c <= v.doneCyc - 1) ? oh : '0;
            expReady = (v.len > 0 && c >= 2 && c <= v.doneCyc - 2) ? oh : '0;
            expEn    = (expReady != '0) && iValid[v.req];
            chk({tag, "_gnt"},    oGnt,    expGnt);
            chk({tag, "_ready"},  oReady,  expReady);
            chk({tag, "_accClr"}, oAccClr, (c == 1));
            chk({tag, "_accEn"},  oAccEn,  expEn);
            if (expEn) chk({tag, "_accData"}, oAccData, v.words[c-2]);
            if (oAccEn) enCnt++;
            chk({tag, "_done"}, oDone, (c == v.doneCyc));
            if (c == v.doneCyc) begin
                chk({tag, "_result"}, oResult, v.sum);
                chk({tag, "_doneId"}, oDoneId, v.req);
            end
        end
        chk({tag, "_enPulses"}, enCnt, v.len);
    endtask

    vecT tbl[6];

    initial begin
        int nDone;
        int lastCyc;
        logic [IW-1:0] rrId[5];
        logic [BW:0]   rrRes[5];
        bit            sawDone;

        tbl[0] = mkVec(0, 4, 1, 2, 3, 4, 0, 8'hFF, 33'd10, 7);
        tbl[1] = mkVec(2, 3, 5, 100, 7, 200, 9, 8'h15, 33'd21, 8);
        tbl[2] = mkVec(1, 0, 0, 0, 0, 0, 0, 8'hFF, 33'd0, 3);
        tbl[3] = mkVec(3, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 8'hFF, 33'h0FFFFFFFD, 6);
        tbl[4] = mkVec(3, 2, 6, 7, 0, 0, 0, 8'hFF, 33'd13, 5);
        tbl[5] = mkVec(2, 2, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 8'hFF, 33'h0FFFFFFFF, 5);
        rrId  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rrRes = '{33'd1, 33'd2, 33'd3, 33'd4, 33'd1};

        iRst = 1'b1; iReq = '0; iLen = '0; iValid = '0; iData = '0;
        doReset();

        for (int i = 0; i < 6; i++) runVec(tbl[i], $sformatf("vec%0d", i));

        // Round-robin: everyone requests continuously with one-word bursts.
        doReset();
        @(negedge iClk);
        iReq = '1; iValid = '1;
        for (int k = 0; k < NR; k++) begin
            iLen[k*LW +: LW] = LW'(1);
            iData[k*BW +: BW] = BW'(k + 1);
        end
        nDone = 0;
        for (int c = 0; c < 40 && nDone < 5; c++) begin
            if (c > 0) @(negedge iClk);
            #1;
            chk("rr_gntOneHot", $onehot0(oGnt), 1'b1);
            if (oDone) begin
                chk("rr_doneId", oDoneId, rrId[nDone]);
                chk("rr_result", oResult, rrRes[nDone]);
                chk("rr_doneCyc", c, 4 + 4 * nDone);
                nDone++;
            end
        end
        chk("rr_doneCount", nDone, 5);
        @(negedge iClk);
        iReq = '0;
        repeat (6) @(negedge iClk);

        // Reset during RUN after two accepted words of a five-word burst.
        doReset();
        @(negedge iClk);
        iReq = 4'b0001; iLen = '0; iLen[0 +: LW] = LW'(5); iValid = '0;
        @(negedge iClk);
        iReq = '0;
        @(negedge iClk);
        iValid = 4'b0001; iData[0 +: BW] = 32'd10;
        #1; chk("rst_mid_en1", oAccEn, 1'b1);
        @(negedge iClk);
        iData[0 +: BW] = 32'd20;
        #1; chk("rst_mid_en2", oAccEn, 1'b1);
        @(negedge iClk);
        iData[0 +: BW] = 32'd30;
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge iClk);
            #1;
            if (oDone) sawDone = 1'b1;
        end
        chk("rst_mid_noDone", sawDone, 1'b0);
        iValid = '0;
        runVec(mkVec(1, 2, 3, 4, 0, 0, 0, 8'hFF, 33'd7, 5), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad + 1);
        $fatal(1);
    end
endmodule

// File: doc/acc_sched.md
# acc_sched

Round-robin scheduler that shares one ACCUMULATOR instance among NUM_REQ requesters. A granted requester streams a burst of iLen words through the scheduler into the accumulator. The scheduler clears the accumulator before each burst, gates its enable per accepted word, and returns the (BITWIDTH+1)-bit sum tagged with the requester id. It sits between the requesters and the accumulator, driving the accumulator's iEn, iClr and iData, and reading its oData.

## Interface
- BITWIDTH, 32, data word width; the sum is BITWIDTH+1 bits wide.
- NUM_REQ, 4, number of requesters (≥2).
- LEN_W, 8, burst-length field width; maximum burst is 2^LEN_W−1 words.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iReq  in  NUM_REQ  per-requester burst request, level.
- iLen  in  NUM_REQ*LEN_W  packed burst lengths; slice k belongs to requester k and is sampled at grant.
- iValid  in  NUM_REQ  per-requester data valid.
- iData  in  NUM_REQ*BITWIDTH  packed data; slice k belongs to requester k.
- oGnt  out  NUM_REQ  one-hot grant, registered.
- oReady  out  NUM_REQ  per-requester ready; only the granted bit can be 1.
- oAccEn  out  1  to accumulator iEn.
- oAccClr  out  1  to accumulator iClr.
- oAccData  out  BITWIDTH  to accumulator iData.
- iAccData  in  BITWIDTH+1  from accumulator oData.
- oDone  out  1  one-cycle result pulse.
- oDoneId  out  ID_W  id of the finished requester.
- oResult  out  BITWIDTH+1  burst sum, held until the next oDone.

## Operation
- States: IDLE, CLR, RUN, WAIT.
- **IDLE**
  - If any iReq bit is set, pick the first set bit searching from ptr+1 upward, wrapping.
  - Register the winning id, set the oGnt bit for that id, and load cnt from its iLen slice.
  - Go to CLR.
  - If no iReq bit is set, stay in IDLE.
- **CLR**
  - Assert oAccClr for 1 cycle.
  - Set ptr to the granted id.
  - If cnt==0, go to WAIT; otherwise go to RUN.
- **RUN**
  - oReady[id]=1.
  - When iValid[id]=1, a word transfers: oAccEn=1, oAccData=iData slice id (combinational mux), and cnt decrements.
  - The transfer that takes cnt from 1 to 0 moves the state to WAIT.
  - When iValid[id]=0, oAccEn=0 and the state holds; gaps are allowed.
- **WAIT**
  - Lasts 1 cycle, so the accumulator register reflects the last word.
  - At the end of the cycle, register oResult←iAccData, oDoneId←id, oDone←1, oGnt←0.
  - Go to IDLE.
- oDone is high for exactly the 1 cycle after WAIT.
- oAccEn, oAccClr and oReady are combinational decodes of state; they are 0 in IDLE and WAIT.
- iValid and iData of non-granted requesters are ignored.
- Deasserting iReq mid-burst is ignored: the burst completes only after cnt words are transferred.
- Arithmetic: the sum wraps modulo 2^(BITWIDTH+1), exactly as the accumulator does. The scheduler adds no saturation and no overflow flag.
- Reset values:
  - State IDLE, ptr=NUM_REQ−1 (requester 0 wins first), cnt=0.
  - oGnt=0, oDone=0, oDoneId=0, oResult=0.
  - oAccEn=0, oAccClr=0, oReady=0.
- Reset mid-burst: the burst is abandoned and no oDone is produced. Accumulator contents are don't-care, because every burst starts with CLR.

## Timing
- iReq seen in IDLE at cycle t: oGnt is valid at t+1 (CLR), and oReady at t+2.
- With L words and iValid held high:
  - Transfers occur in cycles t+2 … t+1+L.
  - WAIT occurs at t+2+L.
  - oDone occurs at t+3+L.
- A new grant can be issued in the IDLE cycle that coincides with oDone; its oGnt appears at t+4+L.
- L=0: CLR at t+1, WAIT at t+2, oDone at t+3 with oResult=0.
- A requester whose iReq stays high is re-granted only after every other requesting id has been served once (round-robin fairness).
- Simultaneous oDone and a new request: both proceed. oDone is never suppressed.

## Test plan
- **Single burst.** After reset, requester 0 sends len=4 with data 1,2,3,4 back-to-back → oGnt=0001 for 6 cycles, oAccEn high for 4 cycles, oDone 7 cycles after the req cycle, oResult=10, oDoneId=0.
- **Round-robin.** All four requesters hold iReq with len=1 and data=k+1 → oDoneId sequence 0,1,2,3,0 and oResult 1,2,3,4,1; oGnt is always one-hot.
- **Bubbles.** Requester 2 sends len=3 with iValid toggling 1,0,1,0,1 → exactly 3 oAccEn pulses and oResult equals the sum of the 3 accepted words; oReady stays high throughout RUN.
- **Zero length and overflow.**
  - len=0 → oDone 3 cycles after the request, with oResult=0.
  - BITWIDTH=32, len=3, each word 0xFFFFFFFF → oResult=0x2FFFFFFFD mod 2^33 = 0x0FFFFFFFD.
- **Reset mid-burst.** Assert iRst during RUN after 2 of 5 words → the next cycle shows all outputs at reset values and no oDone. A subsequent request from requester 1 is granted (ptr reset) and its sum excludes the stale words.
- **Early iReq drop.** Requester 3 drops iReq after the grant, with len=2 → the burst still completes after 2 transfers, and oDone pulses with oDoneId=3.
